// File: rtl/rggen_register_bus_arbiter.sv
// Round-robin arbiter funnelling HOSTS register-bus masters onto one register block; grant is registered, request
// fields pass through combinationally 1 cycle after valid; a host waits (valid held) until its completion pulse.
module rggen_register_bus_arbiter #(
   parameter int HOSTS         = 2,
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [HOSTS-1:0]               i_host_valid,
   input  logic [2*HOSTS-1:0]             i_host_access,
   input  logic [ADDRESS_WIDTH*HOSTS-1:0] i_host_address,
   input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_write_data,
   input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_strobe,
   output logic [HOSTS-1:0]               o_host_ready,
   output logic [1:0]                     o_host_status,
   output logic [BUS_WIDTH-1:0]           o_host_read_data,
   output logic                           o_register_valid,
   output logic [1:0]                     o_register_access,
   output logic [ADDRESS_WIDTH-1:0]       o_register_address,
   output logic [BUS_WIDTH-1:0]           o_register_write_data,
   output logic [BUS_WIDTH-1:0]           o_register_strobe,
   input  logic                           i_register_ready,
   input  logic [1:0]                     i_register_status,
   input  logic [BUS_WIDTH-1:0]           i_register_read_data
);
   localparam int GW = $clog2(HOSTS);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [GW-1:0]   grant;
   logic [GW-1:0]   grant_next;
   logic [GW-1:0]   ptr;
   logic [GW-1:0]   ptr_next;
   logic [GW-1:0]   sel;
   logic [GW-1:0]   cand;
   logic            sel_found;

   logic [1:0]               host_access     [HOSTS];
   logic [ADDRESS_WIDTH-1:0] host_address    [HOSTS];
   logic [BUS_WIDTH-1:0]     host_write_data [HOSTS];
   logic [BUS_WIDTH-1:0]     host_strobe     [HOSTS];

   for (genvar h = 0; h < HOSTS; h++) begin : g_unpack
      assign host_access[h]     = i_host_access[2*h+:2];
      assign host_address[h]    = i_host_address[ADDRESS_WIDTH*h+:ADDRESS_WIDTH];
      assign host_write_data[h] = i_host_write_data[BUS_WIDTH*h+:BUS_WIDTH];
      assign host_strobe[h]     = i_host_strobe[BUS_WIDTH*h+:BUS_WIDTH];
   end

   // First valid host scanning upward from the priority pointer, wrapping at HOSTS.
   always_comb begin
      sel       = '0;
      cand      = '0;
      sel_found = 1'b0;
      for (int i = 0; i < HOSTS; i++) begin
         cand = GW'((int'(ptr) + i) % HOSTS);
         if (!sel_found && i_host_valid[cand]) begin
            sel_found = 1'b1;
            sel       = cand;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_next;
         grant <= grant_next;
         ptr   <= ptr_next;
      end
   end

   always_comb begin
      state_next            = state;
      grant_next            = grant;
      ptr_next              = ptr;
      o_host_ready          = '0;
      o_host_status         = '0;
      o_host_read_data      = '0;
      o_register_valid      = 1'b0;
      o_register_access     = '0;
      o_register_address    = '0;
      o_register_write_data = '0;
      o_register_strobe     = '0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_next = BUSY;
               grant_next = sel;
            end
         end
         BUSY: begin
            o_register_valid      = 1'b1;
            o_register_access     = host_access[grant];
            o_register_address    = host_address[grant];
            o_register_write_data = host_write_data[grant];
            o_register_strobe     = host_strobe[grant];
            // No timeout: the grant is held until the register block answers.
            if (i_register_ready) begin
               o_host_ready[grant] = 1'b1;
               o_host_status       = i_register_status;
               o_host_read_data    = i_register_read_data;
               state_next          = IDLE;
               ptr_next            = (grant == GW'(HOSTS - 1)) ? '0 : grant + GW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Bench for rggen_register_bus_arbiter with 3 hosts: directed scenarios plus randomized traffic, checked by a
// scoreboard against a transaction-level round-robin model.
module tb_rggen_register_bus_arbiter;
   localparam int H  = 3;
   localparam int AW = 8;
   localparam int BW = 32;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [H-1:0]      host_valid   = '0;
   logic [2*H-1:0]    host_access  = '0;
   logic [AW*H-1:0]   host_address = '0;
   logic [BW*H-1:0]   host_wdata   = '0;
   logic [BW*H-1:0]   host_strobe  = '0;
   logic [H-1:0]      host_ready;
   logic [1:0]        host_status;
   logic [BW-1:0]     host_rdata;
   logic              reg_valid;
   logic [1:0]        reg_access;
   logic [AW-1:0]     reg_address;
   logic [BW-1:0]     reg_wdata;
   logic [BW-1:0]     reg_strobe;
   logic              reg_ready  = 1'b0;
   logic [1:0]        reg_status = '0;
   logic [BW-1:0]     reg_rdata  = '0;

   rggen_register_bus_arbiter #(.HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_host_valid         (host_valid),
      .i_host_access        (host_access),
      .i_host_address       (host_address),
      .i_host_write_data    (host_wdata),
      .i_host_strobe        (host_strobe),
      .o_host_ready         (host_ready),
      .o_host_status        (host_status),
      .o_host_read_data     (host_rdata),
      .o_register_valid     (reg_valid),
      .o_register_access    (reg_access),
      .o_register_address   (reg_address),
      .o_register_write_data(reg_wdata),
      .o_register_strobe    (reg_strobe),
      .i_register_ready     (reg_ready),
      .i_register_status    (reg_status),
      .i_register_read_data (reg_rdata)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Host-side request state, owned by the hosts (test code sets, completion clears).
   bit             h_vld   [H];
   logic [1:0]     h_acc   [H];
   logic [AW-1:0]  h_addr  [H];
   logic [BW-1:0]  h_wd    [H];
   logic [BW-1:0]  h_st    [H];
   bit             reissue [H];

   // Reference model: busy flag, granted host, priority pointer.
   bit             m_busy = 1'b0;
   int             m_g    = 0;
   int             m_ptr  = 0;
   int             busy_cnt = 0;
   int             tgt      = 0;
   int             resp_delay = -1;
   bit             fix_resp = 1'b0;
   logic [1:0]     fix_st   = '0;
   logic [BW-1:0]  fix_rd   = '0;

   typedef struct {
      int             host;
      logic [1:0]     st;
      logic [BW-1:0]  rd;
   } resp_t;
   resp_t          exp_q[$];
   int             grant_log[$];
   logic [1:0]     stat_log[$];
   logic [BW-1:0]  rd_log[$];

   task automatic new_fields(input int h);
      h_acc[h]  = 2'($urandom_range(0, 3));
      h_addr[h] = AW'($urandom);
      h_wd[h]   = $urandom;
      h_st[h]   = $urandom;
   endtask

   task automatic issue(input int h);
      new_fields(h);
      h_vld[h] = 1'b1;
   endtask

   // Stimulus engine: advances the model at each edge, then drives hosts and the register block.
   initial begin
      for (int h = 0; h < H; h++) begin
         h_vld[h] = 1'b0; reissue[h] = 1'b0; h_acc[h] = '0; h_addr[h] = '0; h_wd[h] = '0; h_st[h] = '0;
      end
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            exp_q.delete();
         end else if (m_busy) begin
            if (reg_ready) begin
               m_busy = 1'b0;
               m_ptr  = (m_g + 1) % H;
               if (reissue[m_g]) new_fields(m_g);
               else h_vld[m_g] = 1'b0;
            end
         end else if (host_valid != '0) begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < H; k++) begin
               if (!found && host_valid[(m_ptr + k) % H]) begin
                  found = 1'b1;
                  m_g   = (m_ptr + k) % H;
               end
            end
            m_busy   = 1'b1;
            busy_cnt = 0;
            tgt      = (resp_delay >= 0) ? resp_delay : int'($urandom_range(0, 3));
         end
         #2;
         for (int h = 0; h < H; h++) begin
            host_valid[h]           = h_vld[h];
            host_access[2*h+:2]     = h_acc[h];
            host_address[AW*h+:AW]  = h_addr[h];
            host_wdata[BW*h+:BW]    = h_wd[h];
            host_strobe[BW*h+:BW]   = h_st[h];
         end
         if (rst_n && m_busy && busy_cnt == tgt) begin
            resp_t r;
            reg_ready  = 1'b1;
            reg_status = fix_resp ? fix_st : 2'($urandom_range(0, 3));
            reg_rdata  = fix_resp ? fix_rd : $urandom;
            r.host = m_g; r.st = reg_status; r.rd = reg_rdata;
            exp_q.push_back(r);
         end else begin
            // Idle-cycle ready and junk response fields must never reach a host.
            reg_ready  = (rst_n && !m_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            reg_status = 2'($urandom_range(0, 3));
            reg_rdata  = $urandom;
         end
         if (m_busy) busy_cnt++;
      end
   end

   // Monitor: compares every cycle's outputs against the model and the expected-response queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_reg_valid", reg_valid, 0);
            chk("rst_host_ready", host_ready, 0);
            chk("rst_reg_addr", reg_address, 0);
         end else begin
            chk("reg_valid", reg_valid, m_busy);
            chk("reg_access", reg_access, m_busy ? h_acc[m_g] : 2'b0);
            chk("reg_address", reg_address, m_busy ? h_addr[m_g] : '0);
            chk("reg_wdata", reg_wdata, m_busy ? h_wd[m_g] : '0);
            chk("reg_strobe", reg_strobe, m_busy ? h_st[m_g] : '0);
            if (exp_q.size() != 0) begin
               resp_t e;
               logic [H-1:0] onehot;
               int idx;
               e = exp_q.pop_front();
               onehot = '0;
               onehot[e.host] = 1'b1;
               chk("host_ready", host_ready, onehot);
               chk("host_status", host_status, e.st);
               chk("host_rdata", host_rdata, e.rd);
               idx = -1;
               for (int i = 0; i < H; i++) if (host_ready[i]) idx = i;
               grant_log.push_back(idx);
               stat_log.push_back(host_status);
               rd_log.push_back(host_rdata);
            end else begin
               chk("host_ready_idle", host_ready, 0);
               chk("host_status_idle", host_status, 0);
               chk("host_rdata_idle", host_rdata, 0);
            end
         end
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      grant_log.delete(); stat_log.delete(); rd_log.delete();
   endtask

   task automatic wait_done(input string nm, input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         done = !m_busy && (h_vld[0] | h_vld[1] | h_vld[2]) == 1'b0;
      end
      chk({nm, "_drained"}, done, 1);
   endtask

   task automatic chk_log(input string nm, input int exp_order[$]);
      chk({nm, "_count"}, grant_log.size() >= exp_order.size(), 1);
      for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
         chk(nm, grant_log[i], exp_order[i]);
   endtask

   initial begin
      #1;
      chk("reset_valid", reg_valid, 0);
      chk("reset_ready", host_ready, 0);
      chk("reset_status", host_status, 0);
      chk("reset_rdata", host_rdata, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // Lone read from host 0 with a slow register block.
      resp_delay = 3; fix_resp = 1'b1; fix_st = 2'b00; fix_rd = 32'hA5A5_0001;
      @(posedge clk);
      #1 issue(0); h_acc[0] = 2'b00; h_addr[0] = 8'h10;
      @(negedge clk); chk("t031_valid_before", reg_valid, 0);
      @(negedge clk); chk("t031_valid_after", reg_valid, 1);
      wait_done("t031", 50);
      chk_log("t031_order", '{0});
      if (rd_log.size() > 0) chk("t031_rdata", rd_log[0], 32'hA5A5_0001);

      // Simultaneous requests after reset: host 0 first.
      fix_resp = 1'b0;
      apply_reset();
      resp_delay = 0;
      @(posedge clk); #1 issue(0); issue(1);
      wait_done("t032", 50);
      chk_log("t032_order", '{0, 1});

      // Three hosts permanently requesting.
      apply_reset();
      for (int h = 0; h < H; h++) reissue[h] = 1'b1;
      @(posedge clk); #1 issue(0); issue(1); issue(2);
      for (int c = 0; c < 100 && grant_log.size() < 6; c++) @(posedge clk);
      #1 for (int h = 0; h < H; h++) reissue[h] = 1'b0;
      wait_done("t033", 100);
      chk_log("t033_order", '{0, 1, 2, 0, 1, 2});

      // Late request during BUSY does not steal the grant.
      apply_reset();
      resp_delay = 4;
      @(posedge clk); #1 issue(1);
      repeat (2) @(posedge clk);
      #1 issue(0);
      wait_done("t034", 60);
      chk_log("t034_order", '{1, 0});

      // Reset mid-transaction, then re-arbitration from host 0.
      apply_reset();
      resp_delay = 0;
      @(posedge clk); #1 issue(1);
      wait_done("t035_pre", 50);
      grant_log.delete();
      resp_delay = 50;
      @(posedge clk); #1 issue(1); issue(2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t035_busy_before", reg_valid, 1);
      chk("t035_addr_host2", reg_address, h_addr[2]);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t035_async_valid", reg_valid, 0);
      chk("t035_async_ready", host_ready, 0);
      resp_delay = 1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      wait_done("t035", 60);
      chk_log("t035_order", '{1, 2});

      // Error status on a write.
      apply_reset();
      resp_delay = 1; fix_resp = 1'b1; fix_st = 2'b10; fix_rd = '0;
      @(posedge clk); #1 issue(2); h_acc[2] = 2'b01;
      wait_done("t036", 50);
      chk_log("t036_order", '{2});
      if (stat_log.size() > 0) chk("t036_status", stat_log[0], 2'b10);
      fix_resp = 1'b0;

      // Randomized traffic.
      apply_reset();
      resp_delay = -1;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #1;
         for (int h = 0; h < H; h++)
            if (!h_vld[h] && $urandom_range(0, 3) == 0) issue(h);
      end
      wait_done("random", 300);
      chk("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
